// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the in-order RV32I pipeline: arbitrates load-use,
// slow RAM, jump/branch, trap entry and WFI sleep into per-stage enables and flushes.
module pipeline_ctrl #(
    parameter int unsigned MAX_BUS_WAIT = 15,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_use_hazard,
    input  logic       ram_access_ex,
    input  logic       ram_ready,
    input  logic       jump_ex,
    input  logic       trap_req,
    input  logic       wfi_ex,
    input  logic       irq_pending,
    output logic       stall_n_if,
    output logic       stall_n_if_id,
    output logic       stall_n_id_ex,
    output logic       flush_if_id,
    output logic       flush_id_ex,
    output logic       bus_timeout,
    output logic [1:0] state
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_WFI      = 2'd2;
    localparam logic [1:0] ST_TRAP     = 2'd3;

    localparam logic [7:0] WAIT_LIMIT  = 8'(MAX_BUS_WAIT);
    localparam logic [7:0] WAIT_SAT    = 8'hFF;
    localparam logic [2:0] TRAP_RELOAD = 3'(FLUSH_CYCLES - 1);
    // A single-cycle flush fits entirely in the RUN cycle that saw trap_req.
    localparam logic [1:0] TRAP_TARGET = (FLUSH_CYCLES == 1) ? ST_RUN : ST_TRAP;

    logic [1:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [2:0] trap_cnt_q, trap_cnt_d;
    logic       bus_timeout_q, bus_timeout_d;

    logic       en_if, en_if_id, en_id_ex;
    logic       fl_if_id, fl_id_ex;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        trap_cnt_d    = trap_cnt_q;
        bus_timeout_d = 1'b0;
        en_if         = 1'b1;
        en_if_id      = 1'b1;
        en_id_ex      = 1'b1;
        fl_if_id      = 1'b0;
        fl_id_ex      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (trap_req) begin
                    fl_if_id   = 1'b1;
                    fl_id_ex   = 1'b1;
                    trap_cnt_d = TRAP_RELOAD;
                    state_d    = TRAP_TARGET;
                end else if (ram_access_ex && !ram_ready) begin
                    en_if      = 1'b0;
                    en_if_id   = 1'b0;
                    en_id_ex   = 1'b0;
                    wait_cnt_d = 8'd1;
                    state_d    = ST_MEM_WAIT;
                end else if (wfi_ex && !irq_pending) begin
                    en_if    = 1'b0;
                    en_if_id = 1'b0;
                    en_id_ex = 1'b0;
                    state_d  = ST_WFI;
                end else if (jump_ex) begin
                    fl_if_id = 1'b1;
                    fl_id_ex = 1'b1;
                end else if (load_use_hazard) begin
                    en_if    = 1'b0;
                    en_if_id = 1'b0;
                    fl_id_ex = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                // trap_req is deliberately ignored here; its source keeps it asserted.
                if (ram_ready) begin
                    wait_cnt_d = 8'd0;
                    state_d    = ST_RUN;
                end else begin
                    en_if    = 1'b0;
                    en_if_id = 1'b0;
                    en_id_ex = 1'b0;
                    if (wait_cnt_q >= WAIT_LIMIT) begin
                        bus_timeout_d = 1'b1;
                        wait_cnt_d    = 8'd0;
                        trap_cnt_d    = TRAP_RELOAD;
                        state_d       = ST_TRAP;
                    end else if (wait_cnt_q != WAIT_SAT) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end

            ST_WFI: begin
                en_if    = 1'b0;
                en_if_id = 1'b0;
                en_id_ex = 1'b0;
                if (irq_pending) begin
                    state_d = ST_RUN;
                end
            end

            ST_TRAP: begin
                fl_if_id = 1'b1;
                fl_id_ex = 1'b1;
                if (trap_req) begin
                    trap_cnt_d = TRAP_RELOAD;
                end else if (trap_cnt_q == 3'd0) begin
                    state_d = ST_RUN;
                end else begin
                    trap_cnt_d = trap_cnt_q - 3'd1;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            trap_cnt_q    <= 3'd0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            trap_cnt_q    <= trap_cnt_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    // While reset is held every stage is frozen and filled with bubbles.
    always_comb begin
        if (!rst_n) begin
            stall_n_if    = 1'b0;
            stall_n_if_id = 1'b0;
            stall_n_id_ex = 1'b0;
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
        end else begin
            stall_n_if    = en_if;
            stall_n_if_id = en_if_id;
            stall_n_id_ex = en_id_ex;
            flush_if_id   = fl_if_id;
            flush_id_ex   = fl_id_ex;
        end
    end

    assign bus_timeout = bus_timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with default parameters (MAX_BUS_WAIT=15, FLUSH_CYCLES=2).
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_use_hazard, ram_access_ex, ram_ready, jump_ex;
    logic       trap_req, wfi_ex, irq_pending;
    logic       stall_n_if, stall_n_if_id, stall_n_id_ex;
    logic       flush_if_id, flush_id_ex, bus_timeout;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    pipeline_ctrl #(.MAX_BUS_WAIT(15), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_hazard(load_use_hazard), .ram_access_ex(ram_access_ex),
        .ram_ready(ram_ready), .jump_ex(jump_ex), .trap_req(trap_req),
        .wfi_ex(wfi_ex), .irq_pending(irq_pending),
        .stall_n_if(stall_n_if), .stall_n_if_id(stall_n_if_id),
        .stall_n_id_ex(stall_n_id_ex), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .bus_timeout(bus_timeout), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // stall vector order: {if, if_id, id_ex}; flush vector: {if_id, id_ex}
    task automatic chk_out(input string tag, input logic [2:0] st, input logic [1:0] fl,
                           input logic [1:0] s, input logic bt);
        chk({tag, ".stall"}, 32'({stall_n_if, stall_n_if_id, stall_n_id_ex}), 32'(st));
        chk({tag, ".flush"}, 32'({flush_if_id, flush_id_ex}), 32'(fl));
        chk({tag, ".state"}, 32'(state), 32'(s));
        chk({tag, ".tmo"}, 32'(bus_timeout), 32'(bt));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        load_use_hazard = 0; ram_access_ex = 0; ram_ready = 0; jump_ex = 0;
        trap_req = 0; wfi_ex = 0; irq_pending = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        #3;
        chk_out("reset_hold", 3'b000, 2'b11, 2'd0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk_out("run_idle", 3'b111, 2'b00, 2'd0, 1'b0);

        // load-use bubble
        load_use_hazard = 1; #1;
        chk_out("load_use", 3'b001, 2'b01, 2'd0, 1'b0);
        tick(); load_use_hazard = 0; #1;
        chk_out("load_use_after", 3'b111, 2'b00, 2'd0, 1'b0);

        // priority: trap over jump over load-use
        trap_req = 1; jump_ex = 1; load_use_hazard = 1; #1;
        chk_out("prio_trap", 3'b111, 2'b11, 2'd0, 1'b0);
        tick(); clear_in(); #1;
        chk_out("trap_c1", 3'b111, 2'b11, 2'd3, 1'b0);
        tick();
        chk_out("trap_c2", 3'b111, 2'b11, 2'd3, 1'b0);
        tick();
        chk_out("trap_exit", 3'b111, 2'b00, 2'd0, 1'b0);
        jump_ex = 1; load_use_hazard = 1; #1;
        chk_out("prio_jump", 3'b111, 2'b11, 2'd0, 1'b0);
        tick(); clear_in(); #1;
        chk("prio_jump_next.state", 32'(state), 32'd0);

        // slow RAM, ready three cycles after entry; trap_req ignored while waiting
        ram_access_ex = 1; #1;
        chk_out("ram_enter", 3'b000, 2'b00, 2'd0, 1'b0);
        tick(); ram_access_ex = 0; #1;
        chk_out("ram_w1", 3'b000, 2'b00, 2'd1, 1'b0);
        tick(); trap_req = 1; #1;
        chk_out("ram_w2_trap", 3'b000, 2'b00, 2'd1, 1'b0);
        tick(); trap_req = 0; ram_ready = 1; #1;
        chk_out("ram_ready", 3'b111, 2'b00, 2'd1, 1'b0);
        tick(); ram_ready = 0; #1;
        chk_out("ram_done", 3'b111, 2'b00, 2'd0, 1'b0);

        // bus timeout
        ram_access_ex = 1; #1;
        tick(); ram_access_ex = 0; #1;
        for (int i = 1; i <= 15; i++) begin
            chk_out($sformatf("tmo_wait%0d", i), 3'b000, 2'b00, 2'd1, 1'b0);
            tick();
        end
        chk_out("tmo_pulse", 3'b111, 2'b11, 2'd3, 1'b1);
        tick();
        chk_out("tmo_trap2", 3'b111, 2'b11, 2'd3, 1'b0);
        tick();
        chk_out("tmo_exit", 3'b111, 2'b00, 2'd0, 1'b0);

        // ready arriving in the timeout cycle wins
        ram_access_ex = 1; #1;
        tick(); ram_access_ex = 0; #1;
        for (int i = 1; i <= 14; i++) tick();
        ram_ready = 1; #1;
        chk_out("edge_ready", 3'b111, 2'b00, 2'd1, 1'b0);
        tick(); ram_ready = 0; #1;
        chk_out("edge_ready_after", 3'b111, 2'b00, 2'd0, 1'b0);

        // WFI sleep until irq_pending
        wfi_ex = 1; #1;
        chk_out("wfi_enter", 3'b000, 2'b00, 2'd0, 1'b0);
        tick(); wfi_ex = 0; #1;
        for (int i = 1; i <= 4; i++) begin
            chk_out($sformatf("wfi_sleep%0d", i), 3'b000, 2'b00, 2'd2, 1'b0);
            tick();
        end
        irq_pending = 1; #1;
        chk_out("wfi_irq", 3'b000, 2'b00, 2'd2, 1'b0);
        tick();
        chk_out("wfi_wake", 3'b111, 2'b00, 2'd0, 1'b0);
        wfi_ex = 1; #1;
        chk_out("wfi_nop", 3'b111, 2'b00, 2'd0, 1'b0);
        tick(); clear_in(); #1;
        chk("wfi_nop_next.state", 32'(state), 32'd0);

        // reset in MEM_WAIT with the wait counter at 7
        ram_access_ex = 1; #1;
        tick(); ram_access_ex = 0; #1;
        for (int i = 1; i < 7; i++) tick();
        chk("rst_pre.state", 32'(state), 32'd1);
        #1 rst_n = 1'b0; #1;
        chk_out("rst_async", 3'b000, 2'b11, 2'd0, 1'b0);
        tick();
        chk_out("rst_held", 3'b000, 2'b11, 2'd0, 1'b0);
        rst_n = 1'b1; #1;
        for (int i = 0; i < 12; i++) begin
            chk_out($sformatf("rst_run%0d", i), 3'b111, 2'b00, 2'd0, 1'b0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the in-order RV32I pipeline. Drives the stall_n and flush inputs of the IF, IF/ID and ID/EX pipeline registers. Arbitrates between the hazard sources: load-use, slow RAM access, taken jump/branch, trap entry and WFI sleep. It sits beside the core datapath and owns no data.

Parameters:
MAX_BUS_WAIT, 15, cycles a RAM access may wait for ram_ready before timeout (1..255).
FLUSH_CYCLES, 2, cycles the TRAP state holds both flushes asserted (1..7).

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
load_use_hazard  in  1  ID reads a register written by the load currently in EX
ram_access_ex  in  1  EX issues a RAM load/store this cycle
ram_ready  in  1  RAM/bus completes the access this cycle
jump_ex  in  1  EX resolved a taken branch/jump
trap_req  in  1  exception or interrupt accepted; PC redirects to trap vector
wfi_ex  in  1  WFI instruction in EX
irq_pending  in  1  enabled interrupt pending
stall_n_if  out  1  PC/IF advance enable
stall_n_if_id  out  1  IF/ID register enable
stall_n_id_ex  out  1  ID/EX register enable
flush_if_id  out  1  IF/ID insert NOP
flush_id_ex  out  1  ID/EX insert NOP
bus_timeout  out  1  registered one-cycle pulse on RAM timeout
state  out  2  current state, RUN=0 MEM_WAIT=1 WFI=2 TRAP=3

Behaviour:
- Async reset (rst_n=0): state=RUN, wait counter=0, trap counter=0, bus_timeout=0. While rst_n=0, all stall_n_*=0 and both flush_*=1.
- Stall/flush outputs are combinational from state and inputs (zero latency). State, counters and bus_timeout are registered.
- Defaults: all stall_n_*=1, flush_*=0.
- RUN priority (highest first):
  1. trap_req: flush_if_id=flush_id_ex=1; go TRAP, trap counter=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, go directly back to RUN instead.
  2. ram_access_ex && !ram_ready: all stall_n_*=0; go MEM_WAIT, wait counter=1.
  3. wfi_ex && !irq_pending: all stall_n_*=0; go WFI. With irq_pending=1, WFI is a NOP and the pipeline stays in RUN.
  4. jump_ex: flush_if_id=flush_id_ex=1; this overrides load_use_hazard in the same cycle.
  5. load_use_hazard: stall_n_if=stall_n_if_id=0, flush_id_ex=1 (one bubble). Repeats each cycle the hazard persists.
- MEM_WAIT:
  - All stall_n_*=0; trap_req is ignored (the source holds it).
  - ram_ready=1: stall_n_* all 1 in that same cycle; go RUN.
  - Otherwise the wait counter increments. When the counter equals MAX_BUS_WAIT and ram_ready=0: bus_timeout=1 next cycle for exactly one cycle; go TRAP with flushes asserted.
  - ram_ready in the timeout cycle wins: no timeout.
- WFI:
  - All stall_n_*=0.
  - irq_pending=1: go RUN next cycle (still stalled this cycle). trap_req is evaluated in RUN.
- TRAP:
  - Both flush_*=1; stall_n_*=1 so the PC loads the trap vector.
  - Trap counter decrements; at 0, go RUN.
  - trap_req while in TRAP restarts the counter at FLUSH_CYCLES-1.
- Counters saturate and never wrap. The wait counter is 8 bits.
- Reset mid-MEM_WAIT/WFI/TRAP: immediate return to RUN, counters cleared, pending bus_timeout dropped.

Test Plan:
- Load-use: load_use_hazard=1 for 1 cycle in RUN -> stall_n_if=stall_n_if_id=0, flush_id_ex=1, stall_n_id_ex=1 that cycle; state stays 0.
- Slow RAM: ram_access_ex=1, ram_ready rises 3 cycles later -> state=1 for 3 cycles, all stall_n=0, all stall_n=1 in the ram_ready cycle, then state=0; bus_timeout never 1.
- Timeout: ram_access_ex=1, ram_ready=0 forever, MAX_BUS_WAIT=15 -> bus_timeout pulses once 15 cycles after entry, state=3 for 2 cycles with both flushes=1, then state=0.
- Priority: trap_req=jump_ex=load_use_hazard=1 in RUN -> both flushes=1, all stall_n=1, next state=3; jump_ex+load_use_hazard only -> both flushes=1, stall_n all 1.
- WFI: wfi_ex=1, irq_pending=0, raise irq_pending after 5 cycles -> state=2, stalls held 6 cycles, state=0 one cycle after irq_pending; wfi_ex with irq_pending=1 -> no stall.
- Reset: assert rst_n=0 in MEM_WAIT at counter=7 -> state=0 asynchronously, stall_n=0 and flush=1 while low, normal RUN after release, no bus_timeout.
